// File: rtl/clk_meas_pkg.sv
// Shared types and default constants for the clock period meter.
package clk_meas_pkg;

    localparam int unsigned DEF_CNT_W   = 32;
    localparam int unsigned DEF_TIMEOUT = 12_000_000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARM  = 2'd1,
        MEAS = 2'd2
    } meas_state_e;

endpackage

// File: rtl/edge_sync.sv
// Synchronizes an asynchronous input into clk_in and flags its rising edges.
module edge_sync #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk_in,
    input  logic rst,
    input  logic sig_in,
    output logic sig_s,
    output logic rise
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sig_d;

    // NOTE: clocked state always uses <=, so every flop samples pre-edge values and the chain shifts by exactly one stage per clock.
    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
            sig_d  <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], sig_in};
            sig_d  <= sync_q[SYNC_STAGES-1];
        end
    end

    assign sig_s = sync_q[SYNC_STAGES-1];
    assign rise  = sig_s & ~sig_d;

endmodule

// File: rtl/clk_period_meter.sv
// Measures period and high time of an asynchronous slow signal in clk_in cycles,
// re-arming after TIMEOUT cycles without a rising edge.
module clk_period_meter
    import clk_meas_pkg::*;
#(
    parameter int unsigned CNT_W       = DEF_CNT_W,
    parameter int unsigned TIMEOUT     = DEF_TIMEOUT,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic             clk_in,
    input  logic             rst,
    input  logic             sig_in,
    input  logic             en,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] high_time,
    output logic             meas_valid,
    output logic             timeout,
    output logic             busy
);

    if (SYNC_STAGES < 2) begin : g_bad_sync
        $error("SYNC_STAGES must be at least 2");
    end
    if (TIMEOUT < 1 || 64'(TIMEOUT) >= (64'd1 << CNT_W)) begin : g_bad_timeout
        $error("TIMEOUT must lie in 1 .. 2**CNT_W-1");
    end

    localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(TIMEOUT - 1);

    meas_state_e      state, state_next;
    logic             sig_s, rise;
    logic [CNT_W-1:0] cnt, hcnt, wcnt;
    logic             wait_hit, take_meas, fire_timeout, load_rise;

    edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_edge_sync (
        .clk_in (clk_in),
        .rst    (rst),
        .sig_in (sig_in),
        .sig_s  (sig_s),
        .rise   (rise)
    );

    // wcnt counts cycles since entry/last rise; this cycle is the TIMEOUT-th one.
    assign wait_hit = (wcnt == WAIT_LAST);
    assign busy     = (state != IDLE);

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // NOTE: every output of this block is defaulted first, so no path can leave one unassigned and infer a latch.
    always_comb begin
        state_next   = state;
        take_meas    = 1'b0;
        fire_timeout = 1'b0;
        load_rise    = 1'b0;
        if (!en) begin
            state_next = IDLE;
        end else begin
            unique case (state)
                IDLE: state_next = ARM;
                ARM: begin
                    if (rise) begin
                        state_next = MEAS;
                        load_rise  = 1'b1;
                    end else if (wait_hit) begin
                        fire_timeout = 1'b1;
                    end
                end
                MEAS: begin
                    if (rise) begin
                        load_rise = 1'b1;
                        take_meas = 1'b1;
                    end else if (wait_hit) begin
                        fire_timeout = 1'b1;
                        state_next   = ARM;
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            period     <= '0;
            high_time  <= '0;
            meas_valid <= 1'b0;
            timeout    <= 1'b0;
            cnt        <= '0;
            hcnt       <= '0;
            wcnt       <= '0;
        end else begin
            meas_valid <= take_meas;
            timeout    <= fire_timeout;
            if (take_meas) begin
                period    <= cnt;
                high_time <= hcnt;
            end
            if (!en || state == IDLE || fire_timeout) begin
                cnt  <= '0;
                hcnt <= '0;
                wcnt <= '0;
            end else if (load_rise) begin
                // The rise cycle itself is high, so it seeds both counts.
                cnt  <= CNT_W'(1);
                hcnt <= CNT_W'(1);
                wcnt <= '0;
            end else begin
                wcnt <= wcnt + 1'b1;
                if (state == MEAS) begin
                    cnt <= cnt + 1'b1;
                    if (sig_s) hcnt <= hcnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: doc/clk_period_meter.md
CLK_PERIOD_METER -- requirements
Module: clk_period_meter

Interface
REQ-001 SHALL have parameter CNT_W, default 32, meaning the width of the period and high-time counters and outputs.
REQ-002 SHALL have parameter TIMEOUT, default 12000000, meaning the number of clk_in cycles without a rising edge before a timeout is declared.
REQ-003 SHALL have parameter SYNC_STAGES, default 2, meaning the flop count of the sig_in synchronizer (minimum 2).
REQ-004 SHALL have port clk_in, input, 1 bit: the single system clock; all logic on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-006 SHALL have port sig_in, input, 1 bit: the asynchronous slow clock or pulse train to be measured, e.g. a divided clock.
REQ-007 SHALL have port en, input, 1 bit: measurement enable.
REQ-008 SHALL have port period, output, CNT_W bits: clk_in cycles between the last two rising edges of sig_in.
REQ-009 SHALL have port high_time, output, CNT_W bits: clk_in cycles sig_in was high within that period.
REQ-010 SHALL have port meas_valid, output, 1 bit: one-cycle pulse when period and high_time update.
REQ-011 SHALL have port timeout, output, 1 bit: one-cycle pulse when no edge is seen for TIMEOUT cycles.
REQ-012 SHALL have port busy, output, 1 bit: high whenever the state is not IDLE.

Function
REQ-013 SHALL pass sig_in through SYNC_STAGES flops to produce sig_s, and SHALL register sig_s once more as sig_d.
REQ-014 SHALL assert rise combinationally when sig_s=1 and sig_d=0.
REQ-015 SHALL implement an FSM with states IDLE, ARM and MEAS.
REQ-016 SHALL transition IDLE->ARM when en=1.
REQ-017 SHALL transition ARM->MEAS on rise.
REQ-018 SHALL transition MEAS->MEAS on rise, completing a measurement.
REQ-019 SHALL transition ARM->ARM or MEAS->ARM on timeout.
REQ-020 SHALL transition from any state to IDLE on the cycle after en=0, clearing the counters while holding period and high_time.
REQ-021 SHALL, on rise, load cnt<=1, and SHALL load hcnt<=1.
REQ-022 SHALL, in MEAS without rise, increment cnt every cycle and increment hcnt when sig_s=1.
REQ-023 SHALL, on rise in MEAS, register period<=cnt and high_time<=hcnt, and SHALL pulse meas_valid high for exactly 1 cycle (latency 1 clk_in after rise).
REQ-024 SHALL keep a wait counter in ARM and in MEAS that counts cycles since entry or since the last rise; when it reaches TIMEOUT, timeout SHALL pulse for 1 cycle, cnt, hcnt and the wait counter SHALL clear, and the state SHALL become ARM.
REQ-025 SHALL give rise priority over timeout when both occur in the same cycle (measurement taken, no timeout pulse).
REQ-026 SHALL never wrap any counter; TIMEOUT < 2**CNT_W SHALL be checked at elaboration.
REQ-027 SHALL keep period and high_time stable between meas_valid pulses and across timeout.
REQ-028 SHALL never produce high_time > period; a constantly high sig_in SHALL produce a timeout, not a measurement.

Reset
REQ-029 SHALL, while rst=1, asynchronously force: state IDLE; period=0; high_time=0; meas_valid=0; timeout=0; busy=0; all counters and synchronizer flops 0.
REQ-030 SHALL, after rst deassertion with en=1, require one fresh rise to re-arm; no measurement SHALL span a reset, and reset mid-measurement SHALL discard partial counts.

Structure
REQ-031 SHALL place the FSM state enum (IDLE/ARM/MEAS) and the default CNT_W/TIMEOUT constants in the shared package clk_meas_pkg.
REQ-032 SHALL instantiate one sub-module, edge_sync, containing the synchronizer chain, the sig_d register and the rise output.

Verification
REQ-033 SHALL cover: rst=1 mid-MEAS -> all outputs 0 immediately; after release, the first meas_valid only after two new rising edges.
REQ-034 SHALL cover: sig_in period 10 cycles, high 4, en=1 -> from the second rise onward, meas_valid every 10 cycles with period=10, high_time=4.
REQ-035 SHALL cover: sig_in period 6, high 3 (divider output at TOTAL_CYCLE=6-style) -> period=6, high_time=3, pulses spaced 6 cycles.
REQ-036 SHALL cover: TIMEOUT=20, sig_in held at 0 after one rise -> timeout pulse 20 cycles later, state ARM, period unchanged.
REQ-037 SHALL cover: rise on the exact cycle the wait counter hits TIMEOUT -> meas_valid=1, timeout=0.
REQ-038 SHALL cover: en dropped for 5 cycles mid-period -> busy=0 on the next cycle, no meas_valid; after re-enable, period is correct from the second new rise.
